// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

    // Operation phases: waiting for operands, iterating over multiplier bits, holding the result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2 with a floor of 1 so a counter always has at least one bit
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_shift_add_multiplier.sv
// Sequential M x N shift-and-add multiplier, one multiplier bit per clock,
// unsigned or two's-complement per operation, with early exit once the
// remaining multiplier bits are zero.
module seq_shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           signed_mode,
    input  logic [M-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M+N-1:0] product,
    output logic           busy
);

    // Bit counter width depends on the instance's N, so it is sized here with the package helper
    localparam int unsigned CNT_W = clog2(N);
    localparam int          W     = M + N;

    state_t             state;
    logic [W-1:0]       acc;
    logic [W-1:0]       mcand;
    logic [N-1:0]       mplier;
    logic [CNT_W-1:0]   cnt;
    logic               sgn;

    logic               accept;
    logic               last_bit;
    logic               msb_step;
    logic [W-1:0]       addend;
    logic [W-1:0]       acc_next;

    // Step logic: add the multiplicand, or subtract it for the negatively weighted signed MSB
    always_comb begin
        accept   = (state == IDLE) && in_valid;
        msb_step = (cnt == CNT_W'(N - 1));
        last_bit = msb_step || (mplier[N-1:1] == '0);
        addend   = (sgn && msb_step) ? (~mcand + W'(1)) : mcand;
        acc_next = mplier[0] ? (acc + addend) : acc;
    end

    // Datapath: operand capture on accept, shift/accumulate during RUN, product load on the last step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            sgn     <= 1'b0;
            product <= '0;
        end else if (accept) begin
            acc     <= '0;
            mcand   <= {{N{a[M-1] & signed_mode}}, a};
            mplier  <= b;
            cnt     <= '0;
            sgn     <= signed_mode;
        end else if (state == RUN) begin
            acc    <= acc_next;
            mcand  <= {mcand[W-2:0], 1'b0};
            mplier <= {1'b0, mplier[N-1:1]};
            cnt    <= cnt + CNT_W'(1);
            if (last_bit) begin
                product <= acc_next;
            end
        end
    end

    // Control FSM with registered handshake and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_bit) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
